// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW instruction-memory slice: default geometry and fetch FSM encoding.
package vliw_pkg;

    localparam int PARCEL_W_DEF = 16;
    localparam int FETCH_N_DEF  = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

endpackage

// File: rtl/vliw_imem_slot_mux.sv
// One bundle slot: picks parcel base_addr+K from the memory image, zero-filled past the end.
// With IMEM_PARITY_EN it also flags a stored-parity mismatch for an in-range parcel.
module vliw_imem_slot_mux
    import vliw_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int PARCEL_W = PARCEL_W_DEF,
    parameter int K        = 0
) (
    input  logic [$clog2(DEPTH)-1:0]         base_addr,
    input  logic [DEPTH-1:0][PARCEL_W-1:0]   mem_arr,
`ifdef IMEM_PARITY_EN
    input  logic [DEPTH-1:0]                 par_arr,
    output logic                             slot_err,
`endif
    output logic [PARCEL_W-1:0]              slot_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] OFFSET = (AW+1)'(K);

`ifdef IMEM_PARITY_EN
    function automatic logic even_par(input logic [PARCEL_W-1:0] d);
        return ^d;
    endfunction
`endif

    logic [AW:0]   addr_ext_s;
    logic [AW-1:0] idx_s;
    logic          in_range_s;

    // Extra address bit keeps the end-of-memory compare from wrapping.
    always_comb begin
        addr_ext_s = {1'b0, base_addr} + OFFSET;
        idx_s      = addr_ext_s[AW-1:0];
        in_range_s = (addr_ext_s < LIMIT);
        if (in_range_s) begin
            slot_data = mem_arr[idx_s];
        end else begin
            slot_data = '0;
        end
`ifdef IMEM_PARITY_EN
        if (in_range_s) begin
            slot_err = (par_arr[idx_s] != even_par(mem_arr[idx_s]));
        end else begin
            slot_err = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/vliw_imem_fetch.sv
// Runtime-loadable VLIW instruction memory returning FETCH_N-parcel bundles; state updates on falling clk.
// Optional parity protection of stored parcels is enabled by defining IMEM_PARITY_EN.
module vliw_imem_fetch
    import vliw_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int PARCEL_W = PARCEL_W_DEF,
    parameter int FETCH_N  = FETCH_N_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [$clog2(DEPTH)-1:0]      ld_addr,
    input  logic [PARCEL_W-1:0]           ld_data,
`ifdef IMEM_PARITY_EN
    input  logic                          par_inject,
`endif
    input  logic                          fe_req,
    output logic                          fe_ready,
    input  logic [$clog2(DEPTH)-1:0]      fe_addr,
    output logic                          fe_valid,
    output logic [FETCH_N*PARCEL_W-1:0]   fe_bundle,
    output logic                          fe_err,
    output logic                          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    imem_state_e                   state_q, state_d;
    logic [AW-1:0]                 clr_ptr_q, clr_ptr_d;
    logic                          fe_valid_q, fe_valid_d;
    logic [FETCH_N*PARCEL_W-1:0]   fe_bundle_q, fe_bundle_d;
    logic [DEPTH-1:0][PARCEL_W-1:0] mem_q;

    logic                          wr_en_s;
    logic [AW-1:0]                 wr_addr_s;
    logic [PARCEL_W-1:0]           wr_data_s;
    logic [FETCH_N*PARCEL_W-1:0]   bundle_s;

`ifdef IMEM_PARITY_EN
    logic [DEPTH-1:0]              par_q;
    logic                          wr_par_s;
    logic [FETCH_N-1:0]            slot_err_s;
    logic                          fe_err_q, fe_err_d;

    function automatic logic even_par(input logic [PARCEL_W-1:0] d);
        return ^d;
    endfunction
`endif

    for (genvar k = 0; k < FETCH_N; k++) begin : g_slot
        vliw_imem_slot_mux #(
            .DEPTH    (DEPTH),
            .PARCEL_W (PARCEL_W),
            .K        (k)
        ) u_slot_mux (
            .base_addr (fe_addr),
            .mem_arr   (mem_q),
`ifdef IMEM_PARITY_EN
            .par_arr   (par_q),
            .slot_err  (slot_err_s[k]),
`endif
            .slot_data (bundle_s[k*PARCEL_W +: PARCEL_W])
        );
    end

    // FSM next state, memory write port selection and fetch result capture.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        fe_valid_d  = 1'b0;
        fe_bundle_d = fe_bundle_q;
        wr_en_s     = 1'b0;
        wr_addr_s   = '0;
        wr_data_s   = '0;
`ifdef IMEM_PARITY_EN
        wr_par_s    = 1'b0;
        fe_err_d    = fe_err_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (ld_valid) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ld_addr;
                    wr_data_s = ld_data;
`ifdef IMEM_PARITY_EN
                    wr_par_s  = even_par(ld_data) ^ par_inject;
`endif
                end else begin
                    wr_en_s   = 1'b0;
                end
                // bundle_s reads mem_q before this edge's write lands: read-before-write.
                if (fe_req) begin
                    fe_valid_d  = 1'b1;
                    fe_bundle_d = bundle_s;
`ifdef IMEM_PARITY_EN
                    fe_err_d    = |slot_err_s;
`endif
                end else begin
                    fe_valid_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Control and fetch-result registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            fe_valid_q  <= 1'b0;
            fe_bundle_q <= '0;
`ifdef IMEM_PARITY_EN
            fe_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            fe_valid_q  <= fe_valid_d;
            fe_bundle_q <= fe_bundle_d;
`ifdef IMEM_PARITY_EN
            fe_err_q    <= fe_err_d;
`endif
        end
    end

    // Parcel storage; contents are cleared by the FSM rather than by reset.
    always_ff @(negedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
`ifdef IMEM_PARITY_EN
            par_q[wr_addr_s] <= wr_par_s;
`endif
        end
    end

    assign ld_ready  = (state_q == ST_RUN);
    assign fe_ready  = (state_q == ST_RUN);
    assign busy      = (state_q == ST_CLEAR);
    assign fe_valid  = fe_valid_q;
    assign fe_bundle = fe_bundle_q;
`ifdef IMEM_PARITY_EN
    assign fe_err    = fe_err_q;
`else
    assign fe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vliw_imem_fetch.sv
// Directed bench for vliw_imem_fetch: clear sequencing, load/fetch vectors, boundary zero-fill, reset abort.
module tb_vliw_imem_fetch;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;
    logic        par_inject;
    logic        fe_req;
    logic        fe_ready;
    logic [4:0]  fe_addr;
    logic        fe_valid;
    logic [47:0] fe_bundle;
    logic        fe_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    vliw_imem_fetch #(.DEPTH(32), .PARCEL_W(16), .FETCH_N(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
`ifdef IMEM_PARITY_EN
        .par_inject (par_inject),
`endif
        .fe_req     (fe_req),
        .fe_ready   (fe_ready),
        .fe_addr    (fe_addr),
        .fe_valid   (fe_valid),
        .fe_bundle  (fe_bundle),
        .fe_err     (fe_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_v;
        logic [4:0]  ld_a;
        logic [15:0] ld_d;
        logic        fe_r;
        logic [4:0]  fe_a;
        logic        exp_v;
        logic [47:0] exp_b;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the rising edge; the DUT acts on the falling edge; outputs sampled 1 after it.
    task automatic drive(input logic lv, input logic [4:0] la, input logic [15:0] ldd,
                         input logic fr, input logic [4:0] fa, input logic pi);
        @(posedge clk);
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ldd;
        fe_req     = fr;
        fe_addr    = fa;
        par_inject = pi;
        @(negedge clk);
        #1;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            chk({tag, "_fe_valid_in_clear"}, 64'(fe_valid), 64'd0);
        end
        chk({tag, "_clear_edges"}, 64'(n), 64'd32);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_ld_ready_after"}, 64'(ld_ready), 64'd1);
        chk({tag, "_fe_ready_after"}, 64'(fe_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd0,  16'hA001, 1'b0, 5'd0,  1'b0, 48'h0};
        vecs[1]  = '{1'b1, 5'd1,  16'hB002, 1'b0, 5'd0,  1'b0, 48'h0};
        vecs[2]  = '{1'b1, 5'd2,  16'hC003, 1'b0, 5'd0,  1'b0, 48'h0};
        vecs[3]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  1'b1, 48'hC003_B002_A001};
        vecs[4]  = '{1'b1, 5'd30, 16'h1111, 1'b0, 5'd0,  1'b0, 48'hC003_B002_A001};
        vecs[5]  = '{1'b1, 5'd31, 16'h2222, 1'b0, 5'd0,  1'b0, 48'hC003_B002_A001};
        vecs[6]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd30, 1'b1, 48'h0000_2222_1111};
        vecs[7]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 1'b1, 48'h0000_0000_2222};
        vecs[8]  = '{1'b1, 5'd5,  16'h1234, 1'b0, 5'd0,  1'b0, 48'h0000_0000_2222};
        vecs[9]  = '{1'b1, 5'd5,  16'hFFFF, 1'b1, 5'd5,  1'b1, 48'h0000_0000_1234};
        vecs[10] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd5,  1'b1, 48'h0000_0000_FFFF};
        vecs[11] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd1,  1'b1, 48'h0000_C003_B002};
        vecs[12] = '{1'b1, 5'd3,  16'hDEAD, 1'b1, 5'd2,  1'b1, 48'h0000_0000_C003};
        vecs[13] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd2,  1'b1, 48'h0000_DEAD_C003};

        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_addr    = 5'd0;
        ld_data    = 16'h0000;
        par_inject = 1'b0;
        fe_req     = 1'b0;
        fe_addr    = 5'd0;
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_fe_ready", 64'(fe_ready), 64'd0);
        chk("rst_fe_valid", 64'(fe_valid), 64'd0);
        chk("rst_fe_bundle", 64'(fe_bundle), 64'd0);
        chk("rst_fe_err", 64'(fe_err), 64'd0);

        // Release with a fetch request pending; it must be ignored for the whole clear.
        @(posedge clk);
        reset  = 1'b1;
        fe_req = 1'b1;
        count_clear("clr1");

        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 1'b0);
        chk("first_fetch_valid", 64'(fe_valid), 64'd1);
        chk("first_fetch_bundle", 64'(fe_bundle), 64'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ld_v, vecs[i].ld_a, vecs[i].ld_d, vecs[i].fe_r, vecs[i].fe_a, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(fe_valid), 64'(vecs[i].exp_v));
            chk($sformatf("vec%0d_bundle", i), 64'(fe_bundle), 64'(vecs[i].exp_b));
            chk($sformatf("vec%0d_err", i), 64'(fe_err), 64'd0);
        end

`ifdef IMEM_PARITY_EN
        drive(1'b1, 5'd7, 16'h0F0F, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd6, 1'b0);
        chk("par_a6_bundle", 64'(fe_bundle), 64'h0000_0F0F_0000);
        chk("par_a6_err", 64'(fe_err), 64'd1);
        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd8, 1'b0);
        chk("par_a8_err", 64'(fe_err), 64'd0);
        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd31, 1'b0);
        chk("par_a31_bundle", 64'(fe_bundle), 64'h0000_0000_2222);
        chk("par_a31_err", 64'(fe_err), 64'd0);
`endif

        // Fetch, then a one-cycle reset pulse with another fetch in flight.
        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 1'b0);
        chk("pre_pulse_valid", 64'(fe_valid), 64'd1);
        chk("pre_pulse_bundle", 64'(fe_bundle), 64'hC003_B002_A001);
        @(posedge clk);
        fe_req = 1'b1;
        reset  = 1'b0;
        #2;
        chk("pulse_fe_valid", 64'(fe_valid), 64'd0);
        chk("pulse_fe_bundle", 64'(fe_bundle), 64'd0);
        chk("pulse_busy", 64'(busy), 64'd1);
        chk("pulse_ld_ready", 64'(ld_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("pulse_edge_fe_valid", 64'(fe_valid), 64'd0);
        @(posedge clk);
        reset = 1'b1;
        count_clear("clr2");

        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 1'b0);
        chk("post_clear_valid", 64'(fe_valid), 64'd1);
        chk("post_clear_bundle", 64'(fe_bundle), 64'd0);
        drive(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b0);
        chk("idle_valid", 64'(fe_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
